vga_lockstep_voter: RTL and testbench

Parametrised output checker for redundant VGA display controllers. It receives HSYNC/VSYNC/RGB from CHANNELS identical controller instances running in lockstep. It drives one registered, voted VGA output and detects and counts divergence between the channels. Status and control are reachable through an AHB-Lite slave port. It sits between the replicated VGA cores and the board pins and generalises the fixed two-way DLS_ERROR compare to 2- or 3-way operation with persistence filtering and software-visible diagnostics.

---
 rtl/vga_lockstep_voter_if.sv | 22 ++
 rtl/vga_lockstep_voter.sv | 175 +++++++++++++++++
 tb/tb_vga_lockstep_voter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_lockstep_voter_if.sv
// AHB-Lite slave bus carrying the register interface of the lockstep voter.
// The bus master (interconnect or testbench) drives HREADY.
interface vga_lockstep_voter_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/vga_lockstep_voter.sv
// Votes HSYNC/VSYNC/RGB from 2 or 3 lockstep VGA controllers, drives one registered output,
// and reports divergence through a sticky flag, a saturating event counter and AHB registers.
module vga_lockstep_voter #(
    parameter int CHANNELS = 2,
    parameter int RGB_W    = 8,
    parameter int PERSIST  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [CHANNELS-1:0]       ch_hsync,
    input  logic [CHANNELS-1:0]       ch_vsync,
    input  logic [CHANNELS*RGB_W-1:0] ch_rgb,
    vga_lockstep_voter_if.slave       ahb,
    output logic                      HSYNC,
    output logic                      VSYNC,
    output logic [RGB_W-1:0]          RGB,
    output logic                      DLS_ERROR
);

    localparam int VW = RGB_W + 2;
    localparam logic [7:0] PERSIST_L = 8'(PERSIST);

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_ERRCNT = 2'd1,
        REG_CTRL   = 2'd2,
        REG_CONFIG = 2'd3
    } reg_e;

    // Per-channel vector and vote
    logic [VW-1:0] chv [CHANNELS];
    logic [VW-1:0] voted;
    logic [2:0]    diff;
    logic [2:0]    fault_mask;
    logic          mismatch_d;

    // State
    logic [VW-1:0]    voted_q;
    logic             mismatch_q;
    logic [7:0]       persist_q,  persist_d;
    logic             dls_q,      dls_d;
    logic [2:0]       faultch_q,  faultch_d;
    logic [CNT_W-1:0] errcnt_q,   errcnt_d;
    logic             en_q,       en_d;

    // AHB pipeline
    logic        addr_ph;
    logic        wr_q;
    reg_e        addr_q;
    logic [31:0] rdata_mux;
    logic [31:0] hrdata_q,   hrdata_d;
    logic        clr_status;
    logic        clr_errcnt;
    logic        ctrl_wr;
    logic        unused_bits;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            chv[i] = {ch_hsync[i], ch_vsync[i], ch_rgb[i*RGB_W +: RGB_W]};
        end
    end

    generate
        if (CHANNELS == 3) begin : g_tmr
            assign voted = (chv[0] & chv[1]) | (chv[0] & chv[2]) | (chv[1] & chv[2]);
        end else begin : g_dmr
            assign voted = chv[0];
        end
    endgenerate

    // NOTE: every variable written in an always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        diff = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            diff[i] = (chv[i] != voted);
        end
        mismatch_d = en_q & (|diff);
        fault_mask = '0;
        if (mismatch_d) begin
            // In 2-way mode the faulty side cannot be identified, so both are blamed
            fault_mask = (CHANNELS == 2) ? 3'b011 : diff;
        end
    end

    // AHB address/data phase decode
    assign addr_ph    = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
    assign clr_status = wr_q && (addr_q == REG_STATUS) && ahb.HWDATA[0];
    assign clr_errcnt = wr_q && (addr_q == REG_ERRCNT);
    assign ctrl_wr    = wr_q && (addr_q == REG_CTRL);

    // Next state; a set in the same cycle as a clear wins
    always_comb begin
        logic [7:0]       persist_base;
        logic [CNT_W-1:0] errcnt_base;

        persist_base = clr_status ? 8'd0 : persist_q;
        persist_d    = 8'd0;
        if (mismatch_d) begin
            persist_d = (persist_base >= PERSIST_L) ? PERSIST_L : persist_base + 8'd1;
        end

        dls_d     = (mismatch_d && (persist_d == PERSIST_L)) | (dls_q & ~clr_status);
        faultch_d = fault_mask | (clr_status ? 3'b000 : faultch_q);

        errcnt_base = clr_errcnt ? '0 : errcnt_q;
        errcnt_d    = errcnt_base;
        if (mismatch_d && !mismatch_q && (errcnt_base != '1)) begin
            errcnt_d = errcnt_base + 1'b1;
        end

        en_d = ctrl_wr ? ahb.HWDATA[0] : en_q;
    end

    // Read data is captured at the end of the address phase, so a read right behind
    // a write to the same register returns the pre-write value.
    always_comb begin
        rdata_mux = '0;
        case (reg_e'(ahb.HADDR[3:2]))
            REG_STATUS: begin
                rdata_mux[0]    = dls_q;
                rdata_mux[1]    = mismatch_q;
                rdata_mux[10:8] = faultch_q;
            end
            REG_ERRCNT: rdata_mux[CNT_W-1:0] = errcnt_q;
            REG_CTRL:   rdata_mux[0] = en_q;
            REG_CONFIG: begin
                rdata_mux[1:0]   = 2'(CHANNELS);
                rdata_mux[15:8]  = 8'(PERSIST);
                rdata_mux[23:16] = 8'(RGB_W);
            end
            default: rdata_mux = '0;
        endcase
        hrdata_d = (addr_ph && !ahb.HWRITE) ? rdata_mux : 32'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            voted_q    <= '0;
            mismatch_q <= 1'b0;
            persist_q  <= 8'd0;
            dls_q      <= 1'b0;
            faultch_q  <= 3'b000;
            errcnt_q   <= '0;
            en_q       <= 1'b1;
            wr_q       <= 1'b0;
            addr_q     <= REG_STATUS;
            hrdata_q   <= 32'd0;
        end else begin
            voted_q    <= voted;
            mismatch_q <= mismatch_d;
            persist_q  <= persist_d;
            dls_q      <= dls_d;
            faultch_q  <= faultch_d;
            errcnt_q   <= errcnt_d;
            en_q       <= en_d;
            wr_q       <= addr_ph & ahb.HWRITE;
            addr_q     <= addr_ph ? reg_e'(ahb.HADDR[3:2]) : addr_q;
            hrdata_q   <= hrdata_d;
        end
    end

    assign HSYNC         = voted_q[VW-1];
    assign VSYNC         = voted_q[VW-2];
    assign RGB           = voted_q[RGB_W-1:0];
    assign DLS_ERROR     = dls_q;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRDATA    = hrdata_q;

    assign unused_bits = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HWDATA[31:1], ahb.HTRANS[0]};

endmodule

// File: tb/tb_vga_lockstep_voter.sv
// Bench for vga_lockstep_voter: a 3-way (PERSIST=1, CNT_W=4) and a 2-way (PERSIST=4) instance,
// register reads checked by a scoreboard, video outputs checked directly.
module tb_vga_lockstep_voter;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    vga_lockstep_voter_if bus_a ();
    vga_lockstep_voter_if bus_b ();

    logic [2:0]  a_hs, a_vs;
    logic [23:0] a_rgb;
    logic        a_HSYNC, a_VSYNC, a_DLS;
    logic [7:0]  a_RGB;

    logic [1:0]  b_hs, b_vs;
    logic [15:0] b_rgb;
    logic        b_HSYNC, b_VSYNC, b_DLS;
    logic [7:0]  b_RGB;

    vga_lockstep_voter #(.CHANNELS(3), .RGB_W(8), .PERSIST(1), .CNT_W(4)) dut_a (
        .HCLK(HCLK), .HRESET(HRESET),
        .ch_hsync(a_hs), .ch_vsync(a_vs), .ch_rgb(a_rgb),
        .ahb(bus_a),
        .HSYNC(a_HSYNC), .VSYNC(a_VSYNC), .RGB(a_RGB), .DLS_ERROR(a_DLS)
    );

    vga_lockstep_voter #(.CHANNELS(2), .RGB_W(8), .PERSIST(4), .CNT_W(16)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET),
        .ch_hsync(b_hs), .ch_vsync(b_vs), .ch_rgb(b_rgb),
        .ahb(bus_b),
        .HSYNC(b_HSYNC), .VSYNC(b_VSYNC), .RGB(b_RGB), .DLS_ERROR(b_DLS)
    );

    localparam logic [31:0] A_STATUS = 32'h0;
    localparam logic [31:0] A_ERRCNT = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_CONFIG = 32'hC;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_a [$];
    string       nm_a  [$];
    logic [31:0] exp_b [$];
    string       nm_b  [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic drive_addr(input int s, input logic wr, input logic [31:0] addr);
        if (s == 0) begin
            bus_a.HSEL = 1'b1; bus_a.HTRANS = 2'b10; bus_a.HWRITE = wr; bus_a.HADDR = addr;
        end else begin
            bus_b.HSEL = 1'b1; bus_b.HTRANS = 2'b10; bus_b.HWRITE = wr; bus_b.HADDR = addr;
        end
    endtask

    task automatic set_idle(input int s);
        if (s == 0) begin
            bus_a.HSEL = 1'b0; bus_a.HTRANS = 2'b00; bus_a.HWRITE = 1'b0; bus_a.HADDR = 32'd0;
        end else begin
            bus_b.HSEL = 1'b0; bus_b.HTRANS = 2'b00; bus_b.HWRITE = 1'b0; bus_b.HADDR = 32'd0;
        end
    endtask

    task automatic set_wdata(input int s, input logic [31:0] d);
        if (s == 0) bus_a.HWDATA = d;
        else        bus_b.HWDATA = d;
    endtask

    task automatic ahb_wr_addr(input int s, input logic [31:0] addr);
        drive_addr(s, 1'b1, addr);
        cyc();
        set_idle(s);
    endtask

    task automatic ahb_write(input int s, input logic [31:0] addr, input logic [31:0] d);
        ahb_wr_addr(s, addr);
        set_wdata(s, d);
        cyc();
        set_wdata(s, 32'd0);
    endtask

    // Issues a read address phase and queues the expected data for the monitor
    task automatic ahb_read(input int s, input logic [31:0] addr, input logic [31:0] exp,
                            input string nm);
        drive_addr(s, 1'b0, addr);
        if (s == 0) begin
            exp_a.push_back(exp); nm_a.push_back(nm);
        end else begin
            exp_b.push_back(exp); nm_b.push_back(nm);
        end
        cyc();
        set_idle(s);
    endtask

    task automatic monitor();
        logic pa, pb;
        forever begin
            @(posedge HCLK);
            pa = bus_a.HSEL & bus_a.HTRANS[1] & ~bus_a.HWRITE & bus_a.HREADY;
            pb = bus_b.HSEL & bus_b.HTRANS[1] & ~bus_b.HWRITE & bus_b.HREADY;
            @(negedge HCLK);
            if (pa) begin
                if (exp_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_a_underflow: got 0x%08h with no expected entry", bus_a.HRDATA);
                end else begin
                    check(nm_a.pop_front(), bus_a.HRDATA, exp_a.pop_front());
                end
            end
            if (pb) begin
                if (exp_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_b_underflow: got 0x%08h with no expected entry", bus_b.HRDATA);
                end else begin
                    check(nm_b.pop_front(), bus_b.HRDATA, exp_b.pop_front());
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        HRESET = 1'b1;
        set_idle(0); set_idle(1);
        bus_a.HREADY = 1'b1; bus_b.HREADY = 1'b1;
        set_wdata(0, 32'd0); set_wdata(1, 32'd0);
        a_hs = 3'b111; a_vs = 3'b000; a_rgb = {3{8'hA5}};
        b_hs = 2'b11;  b_vs = 2'b00;  b_rgb = {2{8'hA5}};
        cyc(3);

        // Reset state
        check("rst_a_rgb",   32'(a_RGB), 32'h0);
        check("rst_a_hsync", 32'(a_HSYNC), 32'h0);
        check("rst_a_dls",   32'(a_DLS), 32'h0);
        check("rst_a_hrdata", bus_a.HRDATA, 32'h0);
        check("rst_a_hready", 32'(bus_a.HREADYOUT), 32'h1);
        check("rst_b_rgb",   32'(b_RGB), 32'h0);
        check("rst_b_dls",   32'(b_DLS), 32'h0);

        // Identical channels, one-cycle latency
        HRESET = 1'b0;
        cyc();
        check("a_rgb_a5",  32'(a_RGB), 32'hA5);
        check("a_hsync_1", 32'(a_HSYNC), 32'h1);
        check("a_vsync_0", 32'(a_VSYNC), 32'h0);
        check("b_rgb_a5",  32'(b_RGB), 32'hA5);
        cyc(100);
        check("a_dls_idle", 32'(a_DLS), 32'h0);
        check("b_dls_idle", 32'(b_DLS), 32'h0);
        ahb_read(0, A_ERRCNT, 32'h0,        "a_errcnt0");
        ahb_read(0, A_CONFIG, 32'h0008_0103, "a_config");
        ahb_read(1, A_CONFIG, 32'h0008_0402, "b_config");
        ahb_read(1, A_CTRL,   32'h1,        "b_ctrl_rst");
        ahb_read(0, A_STATUS, 32'h0,        "a_status0");

        // 3-way, single-cycle fault on channel 1
        a_rgb = {3{8'h00}};
        cyc();
        a_rgb = {8'h00, 8'hFF, 8'h00};
        cyc();
        check("a_vote_masks_ch1", 32'(a_RGB), 32'h00);
        check("a_dls_p1",         32'(a_DLS), 32'h1);
        a_rgb = {3{8'h00}};
        cyc();
        ahb_read(0, A_STATUS, 32'h0000_0201, "a_status_ch1");
        ahb_read(0, A_ERRCNT, 32'h1,         "a_errcnt1");

        // 2-way, PERSIST=4: three 3-cycle bursts never raise the flag
        for (int k = 0; k < 3; k++) begin
            if (k == 1) b_vs = 2'b10;
            else        b_rgb = {8'h11, 8'hA5};
            cyc(3);
            b_rgb = {2{8'hA5}}; b_vs = 2'b00;
            cyc(2);
            check($sformatf("b_dls_burst3_%0d", k), 32'(b_DLS), 32'h0);
        end
        ahb_read(1, A_ERRCNT, 32'h3,         "b_errcnt3");
        ahb_read(1, A_STATUS, 32'h0000_0300, "b_status_mask11");
        b_rgb = {8'h11, 8'hA5};
        cyc(3);
        check("b_dls_after3", 32'(b_DLS), 32'h0);
        cyc();
        check("b_dls_after4", 32'(b_DLS), 32'h1);
        check("b_rgb_ch0",    32'(b_RGB), 32'hA5);
        b_rgb = {2{8'hA5}};
        cyc();
        ahb_read(1, A_ERRCNT, 32'h4, "b_errcnt4");

        // STATUS clear colliding with a new mismatch on channel 0
        ahb_wr_addr(0, A_STATUS);
        set_wdata(0, 32'h1);
        a_rgb = {8'h00, 8'h00, 8'h77};
        cyc();
        set_wdata(0, 32'h0);
        check("a_dls_set_wins", 32'(a_DLS), 32'h1);
        a_rgb = {3{8'h00}};
        cyc();
        ahb_read(0, A_STATUS, 32'h0000_0101, "a_status_newmask");
        ahb_read(0, A_ERRCNT, 32'h2,         "a_errcnt2");
        ahb_write(0, A_STATUS, 32'h1);
        ahb_read(0, A_STATUS, 32'h0, "a_status_cleared");

        // CNT_W=4 saturation, then clear
        for (int k = 0; k < 20; k++) begin
            a_rgb = {8'h00, 8'hFF, 8'h00};
            cyc();
            a_rgb = {3{8'h00}};
            cyc();
        end
        ahb_read(0, A_ERRCNT, 32'hF, "a_errcnt_sat");
        ahb_write(0, A_ERRCNT, 32'h1234);
        ahb_read(0, A_ERRCNT, 32'h0, "a_errcnt_clr");

        // ERRCNT clear colliding with a new mismatch event
        ahb_wr_addr(1, A_ERRCNT);
        set_wdata(1, 32'hFFFF);
        b_rgb = {8'h11, 8'hA5};
        cyc();
        set_wdata(1, 32'h0);
        b_rgb = {2{8'hA5}};
        cyc();
        ahb_read(1, A_ERRCNT, 32'h1, "b_errcnt_inc_wins");

        // Clear STATUS, disable compare, back-to-back read returns pre-write CTRL
        ahb_write(1, A_STATUS, 32'h1);
        ahb_read(1, A_STATUS, 32'h0, "b_status_cleared");
        ahb_wr_addr(1, A_CTRL);
        set_wdata(1, 32'h0);
        ahb_read(1, A_CTRL, 32'h1, "b_ctrl_b2b_old");
        ahb_read(1, A_CTRL, 32'h0, "b_ctrl_new");
        b_rgb = {8'h3C, 8'hA5};
        cyc(6);
        check("b_dls_en0", 32'(b_DLS), 32'h0);
        check("b_rgb_en0", 32'(b_RGB), 32'hA5);
        b_rgb = {2{8'hA5}};
        cyc();
        ahb_read(1, A_ERRCNT, 32'h1, "b_errcnt_en0");
        ahb_read(1, A_STATUS, 32'h0, "b_status_en0");

        // Bitwise majority where channel 0 is outvoted, then reset mid-burst
        ahb_write(0, A_STATUS, 32'h1);
        a_rgb = {8'h33, 8'h22, 8'h11};
        cyc();
        check("a_majority", 32'(a_RGB), 32'h33);
        check("a_dls_maj",  32'(a_DLS), 32'h1);
        ahb_read(0, A_STATUS, 32'h0000_0303, "a_status_live");
        HRESET = 1'b1;
        cyc();
        check("mid_rst_a_rgb",    32'(a_RGB), 32'h0);
        check("mid_rst_a_hsync",  32'(a_HSYNC), 32'h0);
        check("mid_rst_a_dls",    32'(a_DLS), 32'h0);
        check("mid_rst_a_hrdata", bus_a.HRDATA, 32'h0);
        check("mid_rst_b_rgb",    32'(b_RGB), 32'h0);
        check("mid_rst_b_hready", 32'(bus_b.HREADYOUT), 32'h1);
        a_rgb = {3{8'h00}};
        cyc();
        HRESET = 1'b0;
        cyc();
        ahb_read(0, A_ERRCNT, 32'h0, "a_errcnt_post_rst");
        ahb_read(0, A_STATUS, 32'h0, "a_status_post_rst");
        ahb_read(1, A_CTRL,   32'h1, "b_ctrl_post_rst");
        ahb_read(1, A_ERRCNT, 32'h0, "b_errcnt_post_rst");
        cyc(3);

        check("sb_drain_a", 32'(exp_a.size()), 32'h0);
        check("sb_drain_b", 32'(exp_b.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
